// File: rtl/mod_exp_pkg.sv
// Shared constants and FSM state type for the modular exponentiation engine.
// Optional feature macro: RSA_MODEXP_BASE_REDUCE_EN (reduce base mod n first).
package mod_exp_pkg;

  localparam int W  = 64;
  localparam int LW = 8;

  // exp_len value meaning "exponent is zero".
  localparam logic [LW-1:0] EXP_LEN_ZERO = 8'hFF;

  // Edges from an mm_start sample to the mm_done sample.
  localparam int MM_LATENCY = 65;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    REDUCE = 3'd2,
    ITER   = 3'd3,
    SQR    = 3'd4,
    MUL    = 3'd5,
    DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/mod_exp_mod_mul.sv
// Bit-serial interleaved shift-add modular multiplier: p = a*b mod n.
// a is scanned MSB-first, one bit per cycle. Requires b < n and n >= 2.
// Timing: mm_start sampled at edge t loads the operands, edges t+1..t+64
// perform the 64 steps, mm_done is high in the cycle after edge t+64 so the
// consumer samples done and p at edge t+65.
module mod_mul #(
  parameter int W = mod_exp_pkg::W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         mm_start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic [W-1:0] p,
  output logic         mm_done
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  a_q, b_q, n_q, p_q;
  logic [CW-1:0] cnt_q;
  logic          run_q, done_q;

  logic [W:0] dbl, dbl_red, add, add_red, step;

  // One step: P = 2P mod n, then P = P + b mod n when the current a-bit is set.
  // Intermediates carry one extra bit so 2P and P+b cannot overflow.
  always_comb begin
    dbl     = {p_q, 1'b0};
    dbl_red = (dbl >= {1'b0, n_q}) ? dbl - {1'b0, n_q} : dbl;
    add     = dbl_red + {1'b0, b_q};
    add_red = (add >= {1'b0, n_q}) ? add - {1'b0, n_q} : add;
    step    = a_q[W-1] ? add_red : dbl_red;
  end

  // Operand load on start, then W shift-add steps; done pulses after the last.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (mm_start) begin
        a_q   <= a;
        b_q   <= b;
        n_q   <= n;
        p_q   <= '0;
        cnt_q <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        p_q   <= step[W-1:0];
        a_q   <= {a_q[W-2:0], 1'b0};
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign p       = p_q;
  assign mm_done = done_q;

endmodule

// File: rtl/mod_exp.sv
// Left-to-right binary modular exponentiation: result = base^exp mod n.
// Launched by md_start from the bit-length stage (exp_len = MSB index of exp).
// Optional macro RSA_MODEXP_BASE_REDUCE_EN adds a REDUCE pass (base mod n)
// so any base is legal; without it the caller guarantees base < n.
// Handshake: md_start is a one-cycle pulse accepted only in IDLE (never
// queued); busy is high while an exponentiation is in flight; md_end pulses
// for one cycle with result valid and result holds until the next completion.
module mod_exp #(
  parameter int W  = mod_exp_pkg::W,
  parameter int LW = mod_exp_pkg::LW
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  md_start,
  input  logic [W-1:0]          base,
  input  logic [W-1:0]          exp,
  input  logic [LW-1:0]         exp_len,
  input  logic [W-1:0]          n,
  output logic                  busy,
  output logic [W-1:0]          result,
  output logic                  md_end,
  output mod_exp_pkg::state_e   dbg_state
);

  import mod_exp_pkg::*;

  localparam int IW = $clog2(W);

  state_e        state_q, state_d;
  logic [W-1:0]  base_q, exp_q, n_q, br_q, r_q, result_q;
  logic [LW-1:0] i_q;
  logic          mm_pend_q;

  logic          mm_start, mm_done;
  logic [W-1:0]  mm_a, mm_b, mm_p;
  logic          early_exit;

  assign early_exit = (n_q < W'(2)) || (i_q == EXP_LEN_ZERO);

  // Multiplier launch: squares start from ITER so ITER+SQR spans one 66-cycle
  // slot; MUL and REDUCE start in their own first cycle (also 66 cycles).
  always_comb begin
    mm_start = 1'b0;
    mm_a     = r_q;
    mm_b     = r_q;
    case (state_q)
      ITER:   mm_start = (i_q != '0);
      MUL: begin
        mm_b     = br_q;
        mm_start = !mm_pend_q;
      end
`ifdef RSA_MODEXP_BASE_REDUCE_EN
      REDUCE: begin
        mm_a     = base_q;
        mm_b     = W'(1);
        mm_start = !mm_pend_q;
      end
`endif
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (md_start) state_d = CHECK;
      // Early exits preload R and i=0 and leave through ITER, so every
      // completion takes the same ITER->DONE path (md_end two cycles after start).
      CHECK: begin
`ifdef RSA_MODEXP_BASE_REDUCE_EN
        state_d = early_exit ? ITER : REDUCE;
`else
        state_d = ITER;
`endif
      end
`ifdef RSA_MODEXP_BASE_REDUCE_EN
      REDUCE: if (mm_done) state_d = ITER;
`endif
      ITER:   state_d = (i_q == '0) ? DONE : SQR;
      SQR:    if (mm_done) state_d = exp_q[i_q[IW-1:0]] ? MUL : ITER;
      MUL:    if (mm_done) state_d = ITER;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Tracks an outstanding multiply so MUL/REDUCE launch exactly once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         mm_pend_q <= 1'b0;
    else if (mm_start) mm_pend_q <= 1'b1;
    else if (mm_done)  mm_pend_q <= 1'b0;
  end

  // Operand capture, running value R, bit index i and the result register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q   <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      br_q     <= '0;
      r_q      <= '0;
      i_q      <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (md_start) begin
          base_q <= base;
          exp_q  <= exp;
          n_q    <= n;
          br_q   <= base;
          i_q    <= exp_len;
        end
        CHECK: begin
          if (n_q < W'(2)) begin
            r_q <= '0;
            i_q <= '0;
          end else if (i_q == EXP_LEN_ZERO) begin
            r_q <= W'(1);
            i_q <= '0;
          end else begin
            r_q <= base_q;
          end
        end
`ifdef RSA_MODEXP_BASE_REDUCE_EN
        REDUCE: if (mm_done) begin
          r_q  <= mm_p;
          br_q <= mm_p;
        end
`endif
        ITER: begin
          if (i_q == '0) result_q <= r_q;
          else           i_q      <= i_q - LW'(1);
        end
        SQR:  if (mm_done) r_q <= mm_p;
        MUL:  if (mm_done) r_q <= mm_p;
        default: ;
      endcase
    end
  end

  mod_mul #(.W(W)) u_mod_mul (
    .clk      (clk),
    .rstn     (rstn),
    .mm_start (mm_start),
    .a        (mm_a),
    .b        (mm_b),
    .n        (n_q),
    .p        (mm_p),
    .mm_done  (mm_done)
  );

  assign busy      = (state_q == REDUCE) || (state_q == ITER) ||
                     (state_q == SQR)    || (state_q == MUL);
  assign md_end    = (state_q == DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mod_exp.sv
// Self-checking bench for mod_exp: directed table, randomized vectors against
// an arithmetic reference model, and multi-cycle corner sequences.
module tb_mod_exp;

  localparam int W  = 64;
  localparam int LW = 8;
`ifdef RSA_MODEXP_BASE_REDUCE_EN
  localparam int RED_CYC = 66;
  localparam bit MACRO   = 1'b1;
`else
  localparam int RED_CYC = 0;
  localparam bit MACRO   = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          md_start = 1'b0;
  logic [W-1:0]  base = '0;
  logic [W-1:0]  exp = '0;
  logic [LW-1:0] exp_len = '0;
  logic [W-1:0]  n = '0;
  logic          busy, md_end;
  logic [W-1:0]  result;
  mod_exp_pkg::state_e dbg_state;

  always #5 clk = ~clk;

  mod_exp dut (
    .clk       (clk),
    .rstn      (rstn),
    .md_start  (md_start),
    .base      (base),
    .exp       (exp),
    .exp_len   (exp_len),
    .n         (n),
    .busy      (busy),
    .result    (result),
    .md_end    (md_end),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b, input logic [W-1:0] e,
                                           input logic [W-1:0] m);
    logic [127:0] r, bb, mm;
    if (m < 2) return '0;
    mm = {64'd0, m};
    r  = 128'd1;
    bb = {64'd0, b} % mm;
    while (e != 0) begin
      if (e[0]) r = (r * bb) % mm;
      bb = (bb * bb) % mm;
      e  = e >> 1;
    end
    return r[W-1:0];
  endfunction

  function automatic int msb_of(input logic [W-1:0] e);
    int m = -1;
    for (int k = 0; k < W; k++) if (e[k]) m = k;
    return m;
  endfunction

  // Cycles from the start edge to the edge after which md_end is high.
  function automatic int ref_lat(input logic [W-1:0] e, input logic [W-1:0] m);
    int k;
    if (m < 2 || e == 0) return 2;
    k = msb_of(e) + $countones(e) - 1;
    return 2 + 66 * k + RED_CYC;
  endfunction

  // ---------------- driver ----------------
  // Pulses md_start, then watches for md_end within a cycle budget.
  // junk_at > 0 injects a second start pulse that many edges after the start.
  task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [LW-1:0] len,
                        input logic [W-1:0] m, input int budget, input int junk_at,
                        output logic [W-1:0] res, output int edges, output bit seen);
    @(posedge clk); #1;
    base = b; exp = e; exp_len = len; n = m; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    edges = 0;
    seen  = 1'b0;
    res   = '0;
    check("busy_after_start_edge", W'(busy), W'(0));
    while (edges < budget) begin
      @(posedge clk); #1;
      edges++;
      md_start = (edges == junk_at);
      if (edges == junk_at) begin
        base = 64'd65; exp = 64'd17; exp_len = 8'd4; n = 64'd3233;
      end
      if (edges == 1) check("busy_rise", W'(busy), W'(1));
      if (md_end) begin
        seen = 1'b1;
        res  = result;
        check("busy_fall_with_end", W'(busy), W'(0));
        break;
      end
    end
    md_start = 1'b0;
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL md_end_timeout: got no md_end in %0d cycles, required one", budget);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [W-1:0]  b;
    logic [W-1:0]  e;
    logic [LW-1:0] len;
    logic [W-1:0]  m;
    logic [W-1:0]  res;
    int            lat;
    bit            early;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [W-1:0] b, input logic [W-1:0] e, input logic [LW-1:0] len,
                              input logic [W-1:0] m, input logic [W-1:0] res, input int lat,
                              input bit early);
    vec_t v;
    v.b = b; v.e = e; v.len = len; v.m = m; v.res = res; v.lat = lat; v.early = early;
    return v;
  endfunction

  initial begin
    logic [W-1:0] res, rb, re, rm, req;
    int edges, lat, cnt;
    bit seen;

    tbl.push_back(mk(64'd4,  64'd13, 8'd3,  64'd497,  64'd445,  332, 1'b0));
    tbl.push_back(mk(64'd65, 64'd17, 8'd4,  64'd3233, 64'd2790, 332, 1'b0));
    tbl.push_back(mk(64'd5,  64'd0,  8'hFF, 64'd497,  64'd1,    2,   1'b1));
    tbl.push_back(mk(64'd5,  64'd13, 8'd3,  64'd1,    64'd0,    2,   1'b1));
    tbl.push_back(mk(64'd0,  64'd0,  8'hFF, 64'd0,    64'd0,    2,   1'b1));
    tbl.push_back(mk(64'd9,  64'd1,  8'd0,  64'd10,   64'd9,    2,   1'b0));
    tbl.push_back(mk(64'd3,  64'd2,  8'd1,  64'd7,    64'd2,    68,  1'b0));
    tbl.push_back(mk(64'd1,  64'd5,  8'd2,  64'd2,    64'd1,    200, 1'b0));
    tbl.push_back(mk(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'hFFFF_FFFF_FFFF_FFFE, 134, 1'b0));
    if (MACRO) tbl.push_back(mk(64'd501, 64'd13, 8'd3, 64'd497, 64'd445, 332, 1'b0));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   W'(busy),      W'(0));
    check("rst_md_end", W'(md_end),    W'(0));
    check("rst_result", result,        W'(0));
    check("rst_state",  W'(dbg_state), W'(mod_exp_pkg::IDLE));
    @(negedge clk);
    rstn = 1'b1;

    // Directed table.
    foreach (tbl[k]) begin
      exp_q.push_back(tbl[k].res);
      lat = tbl[k].lat + (tbl[k].early ? 0 : RED_CYC);
      run_op(tbl[k].b, tbl[k].e, tbl[k].len, tbl[k].m, lat + 100, 0, res, edges, seen);
      req = exp_q.pop_front();
      if (seen) begin
        check($sformatf("tbl%0d_result", k), res, req);
        check($sformatf("tbl%0d_latency", k), W'(edges), W'(lat));
      end
    end

    // Randomized vectors against the reference model.
    for (int k = 0; k < 10; k++) begin
      rm = (k % 2 == 0) ? W'($urandom_range(2, 1000)) : {$urandom, $urandom};
      if (rm < 2) rm = 64'd3;
      rb = {$urandom, $urandom};
      if (!MACRO) rb = rb % rm;
      re = W'($urandom_range(1, 2047));
      exp_q.push_back(ref_pow(rb, re, rm));
      lat = ref_lat(re, rm);
      run_op(rb, re, LW'(msb_of(re)), rm, lat + 100, 0, res, edges, seen);
      req = exp_q.pop_front();
      if (seen) begin
        check($sformatf("rnd%0d_result", k), res, req);
        check($sformatf("rnd%0d_latency", k), W'(edges), W'(lat));
      end
    end

    // Second start while busy is ignored; start during md_end is ignored too.
    run_op(64'd4, 64'd13, 8'd3, 64'd497, 332 + RED_CYC + 100, 10, res, edges, seen);
    if (seen) begin
      check("busy_start_result",  res,        W'(445));
      check("busy_start_latency", W'(edges),  W'(332 + RED_CYC));
      md_start = 1'b1;
      base = 64'd3; exp = 64'd2; exp_len = 8'd1; n = 64'd7;
      @(posedge clk); #1;
      md_start = 1'b0;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
        if (busy) cnt++;
        @(posedge clk); #1;
      end
      check("start_on_end_ignored", W'(cnt), W'(0));
      cnt = 0;
      for (int k = 0; k < 400; k++) begin
        if (md_end) cnt++;
        @(posedge clk); #1;
      end
      check("extra_md_end_count", W'(cnt), W'(0));
      check("result_held", result, W'(445));
    end

    // Reset in the middle of a squaring aborts immediately.
    @(posedge clk); #1;
    base = 64'd4; exp = 64'd13; exp_len = 8'd3; n = 64'd497; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (20 + RED_CYC) @(posedge clk);
    #1;
    check("pre_reset_state", W'(dbg_state), W'(mod_exp_pkg::SQR));
    rstn = 1'b0;
    #1;
    check("mid_rst_busy",   W'(busy),   W'(0));
    check("mid_rst_md_end", W'(md_end), W'(0));
    check("mid_rst_result", result,     W'(0));
    @(negedge clk);
    rstn = 1'b1;
    run_op(64'd65, 64'd17, 8'd4, 64'd3233, 332 + RED_CYC + 100, 0, res, edges, seen);
    if (seen) begin
      check("post_rst_result",  res,       W'(2790));
      check("post_rst_latency", W'(edges), W'(332 + RED_CYC));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
